// File: rtl/game_ctrl_if.sv
// ---------------------------------------------------------------------------
// game_ctrl_if : start requests, collision verdicts and round outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface game_ctrl_if #(
  parameter int SCORE_W = 8
);
  logic               tick;
  logic               start_local;
  logic               start_remote;
  logic               won;
  logic               lost;
  logic               draw;
  logic               eaten1;
  logic               eaten2;
  logic [2:0]         mode;
  logic               game_rst;
  logic               game_active;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;

  modport master (
    output tick, start_local, start_remote, won, lost, draw, eaten1, eaten2,
    input  mode, game_rst, game_active, score1, score2
  );

  modport slave (
    input  tick, start_local, start_remote, won, lost, draw, eaten1, eaten2,
    output mode, game_rst, game_active, score1, score2
  );
endinterface

`default_nettype wire

// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl : MENU -> WAIT_PEER -> GAME -> WIN/LOSE/DRAW -> MENU round sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module game_ctrl #(
  parameter int SCORE_W      = 8,
  parameter int PEER_TIMEOUT = 64,
  parameter int END_HOLD     = 32
) (
  input  wire logic   clk,
  input  wire logic   rst,
  game_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    MENU      = 3'd0,
    WAIT_PEER = 3'd1,
    GAME      = 3'd2,
    WIN       = 3'd3,
    LOSE      = 3'd4,
    DRAW      = 3'd5
  } mode_e;

  localparam int CNT_MAX = (PEER_TIMEOUT > END_HOLD) ? PEER_TIMEOUT : END_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]   PEER_LIM  = CNT_W'(PEER_TIMEOUT);
  localparam logic [CNT_W-1:0]   HOLD_LIM  = CNT_W'(END_HOLD);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  mode_e              mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               peer_rdy_q, peer_rdy_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic               game_rst_q, game_rst_d;
  logic               game_active_q, game_active_d;
  logic               arm_q, loc_prev_q, rem_prev_q;

  logic               loc_edge, rem_edge, enter_game;
  logic [CNT_W-1:0]   cnt_inc;

  // arm_q masks the first cycle after reset so a level held through reset is not an edge
  assign loc_edge = arm_q & bus.start_local  & ~loc_prev_q;
  assign rem_edge = arm_q & bus.start_remote & ~rem_prev_q;
  assign cnt_inc  = cnt_q + 1'b1;

  always_comb begin
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    peer_rdy_d = peer_rdy_q;
    score1_d   = score1_q;
    score2_d   = score2_q;
    enter_game = 1'b0;
    game_rst_d = 1'b0;

    case (mode_q)
      MENU: begin
        if (rem_edge) peer_rdy_d = 1'b1;
        if (loc_edge) begin
          mode_d = WAIT_PEER;
          cnt_d  = '0;
        end
      end
      WAIT_PEER: begin
        if (rem_edge || peer_rdy_q) begin
          enter_game = 1'b1;
        end else if (bus.tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == PEER_LIM) begin
            mode_d     = MENU;
            peer_rdy_d = 1'b0;
            cnt_d      = '0;
          end
        end
      end
      GAME: begin
        cnt_d = '0;
        if (bus.tick) begin
          if (bus.eaten1 && score1_q != SCORE_MAX) score1_d = score1_q + 1'b1;
          if (bus.eaten2 && score2_q != SCORE_MAX) score2_d = score2_q + 1'b1;
          if (bus.draw || (bus.won && bus.lost)) mode_d = DRAW;
          else if (bus.won)                      mode_d = WIN;
          else if (bus.lost)                     mode_d = LOSE;
        end
      end
      WIN, LOSE, DRAW: begin
        if (loc_edge) begin
          mode_d = WAIT_PEER;
          cnt_d  = '0;
        end else if (bus.tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == HOLD_LIM) begin
            mode_d = MENU;
            cnt_d  = '0;
          end
        end
      end
      default: begin
        mode_d = MENU;
        cnt_d  = '0;
      end
    endcase

    if (enter_game) begin
      mode_d     = GAME;
      game_rst_d = 1'b1;
      score1_d   = '0;
      score2_d   = '0;
      peer_rdy_d = 1'b0;
    end

    game_active_d = (mode_d == GAME);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q        <= MENU;
      cnt_q         <= '0;
      peer_rdy_q    <= 1'b0;
      score1_q      <= '0;
      score2_q      <= '0;
      game_rst_q    <= 1'b0;
      game_active_q <= 1'b0;
      arm_q         <= 1'b0;
      loc_prev_q    <= 1'b0;
      rem_prev_q    <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      cnt_q         <= cnt_d;
      peer_rdy_q    <= peer_rdy_d;
      score1_q      <= score1_d;
      score2_q      <= score2_d;
      game_rst_q    <= game_rst_d;
      game_active_q <= game_active_d;
      arm_q         <= 1'b1;
      loc_prev_q    <= bus.start_local;
      rem_prev_q    <= bus.start_remote;
    end
  end

  assign bus.mode        = mode_q;
  assign bus.game_rst    = game_rst_q;
  assign bus.game_active = game_active_q;
  assign bus.score1      = score1_q;
  assign bus.score2      = score2_q;

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_ctrl : vector table plus hand sequences, queue scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_game_ctrl;

  localparam logic [2:0] M_MENU = 3'd0, M_WAIT = 3'd1, M_GAME = 3'd2,
                         M_WIN  = 3'd3, M_LOSE = 3'd4, M_DRAW = 3'd5;
  // input bit masks: tick, start_local, start_remote, won, lost, draw, eaten1, eaten2
  localparam logic [7:0] T  = 8'h80, SL = 8'h40, SR = 8'h20, WN = 8'h10,
                         LS = 8'h08, DR = 8'h04, E1 = 8'h02, E2 = 8'h01, NONE = 8'h00;

  typedef struct {
    bit         sel;
    logic [7:0] in;
    logic [2:0] mode;
    logic       grst;
    logic [7:0] s1;
    logic [7:0] s2;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;
  vec_t exp_q[$];
  vec_t tbl[18];

  always #5 clk = ~clk;

  game_ctrl_if #(.SCORE_W(8)) bus  ();
  game_ctrl_if #(.SCORE_W(2)) sbus ();

  game_ctrl #(.SCORE_W(8), .PEER_TIMEOUT(64), .END_HOLD(32)) u_dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  game_ctrl #(.SCORE_W(2), .PEER_TIMEOUT(64), .END_HOLD(32)) u_small (
    .clk (clk), .rst (rst), .bus (sbus)
  );

  function automatic vec_t mk(input bit sel, input logic [7:0] in, input logic [2:0] m,
                              input logic g, input logic [7:0] s1, input logic [7:0] s2);
    vec_t v;
    v.sel = sel; v.in = in; v.mode = m; v.grst = g; v.s1 = s1; v.s2 = s2;
    return v;
  endfunction

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, tag, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic [7:0] in);
    if (!sel) begin
      bus.tick = in[7]; bus.start_local = in[6]; bus.start_remote = in[5]; bus.won = in[4];
      bus.lost = in[3]; bus.draw = in[2]; bus.eaten1 = in[1]; bus.eaten2 = in[0];
    end else begin
      sbus.tick = in[7]; sbus.start_local = in[6]; sbus.start_remote = in[5]; sbus.won = in[4];
      sbus.lost = in[3]; sbus.draw = in[2]; sbus.eaten1 = in[1]; sbus.eaten2 = in[0];
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    drive(v.sel, v.in);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    step_no++;
    if (!e.sel) begin
      chk("mode", step_no, 32'(bus.mode), 32'(e.mode));
      chk("game_rst", step_no, 32'(bus.game_rst), 32'(e.grst));
      chk("game_active", step_no, 32'(bus.game_active), 32'(e.mode == M_GAME));
      chk("score1", step_no, 32'(bus.score1), 32'(e.s1));
      chk("score2", step_no, 32'(bus.score2), 32'(e.s2));
    end else begin
      chk("small_mode", step_no, 32'(sbus.mode), 32'(e.mode));
      chk("small_score1", step_no, 32'(sbus.score1), 32'(e.s1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, NONE);
    drive(1'b1, NONE);

    // vector table: start handshake, scoring, verdict priority, result exit
    tbl[0]  = mk(0, NONE,       M_MENU, 0, 0, 0);
    tbl[1]  = mk(0, SL,         M_WAIT, 0, 0, 0);
    tbl[2]  = mk(0, SL,         M_WAIT, 0, 0, 0);
    tbl[3]  = mk(0, SL,         M_WAIT, 0, 0, 0);
    tbl[4]  = mk(0, SL|SR,      M_GAME, 1, 0, 0);
    tbl[5]  = mk(0, SL|SR,      M_GAME, 0, 0, 0);
    tbl[6]  = mk(0, NONE,       M_GAME, 0, 0, 0);
    tbl[7]  = mk(0, T|E1,       M_GAME, 0, 1, 0);
    tbl[8]  = mk(0, T|E1|E2,    M_GAME, 0, 2, 1);
    tbl[9]  = mk(0, WN,         M_GAME, 0, 2, 1);
    tbl[10] = mk(0, E1,         M_GAME, 0, 2, 1);
    tbl[11] = mk(0, T|WN|LS,    M_DRAW, 0, 2, 1);
    tbl[12] = mk(0, T|E1,       M_DRAW, 0, 2, 1);
    tbl[13] = mk(0, SL,         M_WAIT, 0, 2, 1);
    tbl[14] = mk(0, SR,         M_GAME, 1, 0, 0);
    tbl[15] = mk(0, SL,         M_GAME, 0, 0, 0);
    tbl[16] = mk(0, T|WN|E1,    M_WIN,  0, 1, 0);
    tbl[17] = mk(0, SL,         M_WAIT, 0, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mode", 0, 32'(bus.mode), 32'(M_MENU));
    chk("rst_game_rst", 0, 32'(bus.game_rst), 32'd0);
    chk("rst_game_active", 0, 32'(bus.game_active), 32'd0);
    chk("rst_score1", 0, 32'(bus.score1), 32'd0);
    chk("rst_score2", 0, 32'(bus.score2), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) apply(tbl[i]);
    apply(mk(0, NONE, M_WAIT, 0, 1, 0));

    // peer timeout: 64 ticks, interleaved with idle cycles that must not count
    for (int i = 1; i <= 64; i++) begin
      apply(mk(0, T, (i == 64) ? M_MENU : M_WAIT, 0, 1, 0));
      if (i < 64) apply(mk(0, NONE, M_WAIT, 0, 1, 0));
    end

    // remote first, local 10 clk later: peer_rdy path
    apply(mk(0, SR, M_MENU, 0, 1, 0));
    for (int i = 0; i < 9; i++) apply(mk(0, SR, M_MENU, 0, 1, 0));
    apply(mk(0, SR|SL, M_WAIT, 0, 1, 0));
    apply(mk(0, SR,    M_GAME, 1, 0, 0));
    apply(mk(0, NONE,  M_GAME, 0, 0, 0));

    // scoring then WIN held for END_HOLD ticks with scores frozen
    for (int i = 1; i <= 5; i++) apply(mk(0, T|E1, M_GAME, 0, 8'(i), 0));
    for (int i = 1; i <= 2; i++) apply(mk(0, T|E2, M_GAME, 0, 5, 8'(i)));
    apply(mk(0, T|WN, M_WIN, 0, 5, 2));
    for (int i = 1; i <= 32; i++) apply(mk(0, T|E1|E2, (i == 32) ? M_MENU : M_WIN, 0, 5, 2));

    // LOSE exited early by a local edge after 5 ticks
    apply(mk(0, SL,   M_WAIT, 0, 5, 2));
    apply(mk(0, SR,   M_GAME, 1, 0, 0));
    apply(mk(0, T|LS, M_LOSE, 0, 0, 0));
    for (int i = 0; i < 5; i++) apply(mk(0, T, M_LOSE, 0, 0, 0));
    apply(mk(0, SL,   M_WAIT, 0, 0, 0));
    apply(mk(0, NONE, M_WAIT, 0, 0, 0));

    // draw flag alone, then asynchronous reset mid-round
    apply(mk(0, SR,      M_GAME, 1, 0, 0));
    apply(mk(0, T|DR,    M_DRAW, 0, 0, 0));
    apply(mk(0, SL,      M_WAIT, 0, 0, 0));
    apply(mk(0, SR,      M_GAME, 1, 0, 0));
    apply(mk(0, T|E1,    M_GAME, 0, 1, 0));
    @(negedge clk);
    drive(1'b0, NONE);
    #2 rst = 1'b1;
    #1;
    chk("midrst_mode", step_no, 32'(bus.mode), 32'(M_MENU));
    chk("midrst_score1", step_no, 32'(bus.score1), 32'd0);
    chk("midrst_game_active", step_no, 32'(bus.game_active), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply(mk(0, NONE, M_MENU, 0, 0, 0));

    // narrow score counter saturates at 3
    apply(mk(1, NONE, M_MENU, 0, 0, 0));
    apply(mk(1, SL,   M_WAIT, 0, 0, 0));
    apply(mk(1, SR,   M_GAME, 0, 0, 0));
    for (int i = 1; i <= 5; i++) apply(mk(1, T|E1, M_GAME, 0, (i > 3) ? 8'd3 : 8'(i), 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
